noise_power_est: RTL
====================

Name: noise_power_est

Overview:
- Receive-side counterpart of the Gaussian noise generator top. It consumes scaled I/Q noise samples S(8,7), either raw or after the noisy-sum stage.
- Over a window of 2^LOG2_N valid samples it measures mean complex power and per-rail DC mean. Software compares these against the programmed sigma to confirm the channel SNR.
- Two-stage pipeline (square, accumulate) under a two-state FSM, one-cycle result strobe.

Parameters:
- NBT_IN, 8, total bits of input samples
- NBF_IN, 7, fractional bits of input samples
- LOG2_N, 10, log2 of window length; legal range 1..16
- NBT_POW, 16, output power width, unsigned U(16,14), i.e. 2*NBF_IN fractional bits

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  level; 1 = run consecutive windows, 0 = abort/idle
- i_valid  in  1  qualifies i_noise_I/i_noise_Q this cycle
- i_noise_I  in  NBT_IN  signed S(8,7) I sample
- i_noise_Q  in  NBT_IN  signed S(8,7) Q sample
- o_power  out  NBT_POW  unsigned U(16,14), mean of I^2+Q^2 over the window
- o_mean_I  out  NBT_IN  signed S(8,7), mean of I over the window
- o_mean_Q  out  NBT_IN  signed S(8,7), mean of Q over the window
- o_valid  out  1  one-cycle strobe; results updated this cycle
- o_busy  out  1  1 while FSM is in ACCUM

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter/accumulators/pipeline regs 0.
- Stage 1 (registered):
  - sq = I*I + Q*Q as unsigned 16 bit. Max (-128)^2 * 2 = 32768 fits, no saturation.
  - I and Q are registered alongside sq.
  - s1_valid = i_valid & i_enable & (state==ACCUM or entering ACCUM).
- Stage 2 accumulators:
  - acc_p, unsigned NBT_POW+LOG2_N
  - acc_I and acc_Q, signed NBT_IN+LOG2_N
  - cnt, LOG2_N bits
  - On s1_valid, accumulate and increment cnt.
- FSM:
  - IDLE -> ACCUM when i_enable=1. Samples with i_valid on that same cycle are accepted.
  - ACCUM -> IDLE when i_enable=0. Abort: accumulators, cnt and stage-1 valid cleared, no o_valid.
  - ACCUM -> ACCUM at window end. cnt==2^LOG2_N-1 with s1_valid marks window end.
- Window end:
  - Outputs register (acc + current term) >> LOG2_N. Logical shift for power, arithmetic for means (truncation toward -inf).
  - o_valid=1 on the next cycle.
  - Accumulators reload to 0 in the same cycle, so the following sample starts the next window with no gap and no dropped samples.
- Latency: last input sample at cycle t -> o_valid at t+2.
- Outputs hold their value between strobes. An abort does not modify them.
- i_valid gaps: count only valid samples; window length is in samples, not cycles.
- Counter wraps naturally at 2^LOG2_N. No overflow is possible by width choice.
- Reset mid-window clears everything immediately (asynchronous). o_valid never asserts from a partial window.

Optional Feature:
- Macro NOISE_POWER_EST_PEAK_EN.
- Defined:
  - Extra output o_peak, NBT_IN bits unsigned U(8,7): max(|I|,|Q|) over the window.
  - |-128| = 128 is representable.
  - o_peak updates with o_valid and resets to 0.
  - Peak register clears at window start and on abort.
- Undefined: port absent, no peak logic.

Decomposition:
- Package noise_est_pkg holds:
  - fixed-point constants NBT_IN/NBF_IN/NBT_POW/NBF_POW
  - derived accumulator width function acc_w(LOG2_N)
  - FSM state enum {IDLE, ACCUM}
- One sub-module, npe_square_stage: the stage-1 register of sq, I, Q and valid, with synchronous flush input for abort.
- Accumulation and FSM stay in the top.

Test Plan:
- LOG2_N=4, enable, 16 samples I=64, Q=0 -> o_valid at 2 cycles after 16th sample; o_power=4096 (0.25), o_mean_I=64, o_mean_Q=0.
- LOG2_N=4, 16 samples I=-128, Q=-128 -> o_power=32768 (2.0), o_mean_I=o_mean_Q=-128; no overflow.
- LOG2_N=4, I alternating +64/-64, Q=+32 constant, with i_valid pulsed every third cycle -> o_power=5120, o_mean_I=0, o_mean_Q=32; strobe only after 16th valid sample.
- Drop i_enable after 10 samples, re-enable, feed 16 samples I=32, Q=0 -> no o_valid for aborted window; then o_power=1024, prior outputs held until then.
- Continuous enable, 48 back-to-back samples (16×I=64, 16×I=0, 16×I=-64, Q=0) -> three strobes exactly 16 cycles apart; o_mean_I = 64, 0, -64 in order.
- With NOISE_POWER_EST_PEAK_EN, window containing I=-128 once, otherwise |I|,|Q|<=10 -> o_peak=128. Async i_reset mid-window -> all outputs 0 next edge, no strobe.

Source files
------------

// File: rtl/noise_est_pkg.sv
// Shared fixed-point constants, accumulator sizing and FSM states for the
// receive-side noise power estimator.
package noise_est_pkg;

  // Input samples are S(8,7); power is U(16,14), i.e. twice the input fraction.
  localparam int NBT_IN  = 8;
  localparam int NBF_IN  = 7;
  localparam int NBT_POW = 16;
  localparam int NBF_POW = 2 * NBF_IN;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Power accumulator width: one extra bit per doubling of the window length
  // so a full window of worst-case terms never overflows.
  function automatic int acc_w(input int log2_n);
    return NBT_POW + log2_n;
  endfunction

  // Signed mean accumulator width, same reasoning as acc_w.
  function automatic int mean_w(input int log2_n);
    return NBT_IN + log2_n;
  endfunction

endpackage

// File: rtl/npe_square_stage.sv
// Stage 1 of the estimator: registers I*I+Q*Q together with the raw I/Q
// samples and their qualifier. A synchronous flush drops the pending sample
// when the window is aborted.
module npe_square_stage
  import noise_est_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic signed [NBT_IN-1:0] noise_i,
  input  logic signed [NBT_IN-1:0] noise_q,
  output logic        [NBT_POW-1:0] sq,
  output logic signed [NBT_IN-1:0] sample_i,
  output logic signed [NBT_IN-1:0] sample_q,
  output logic                     valid
);

  // Squares are non-negative and each is at most 16384, so the unsigned sum
  // tops out at 32768 and fits 16 bits without saturation.
  logic signed [NBT_POW-1:0] ii;
  logic signed [NBT_POW-1:0] qq;
  logic        [NBT_POW-1:0] sq_next;

  assign ii      = noise_i * noise_i;
  assign qq      = noise_q * noise_q;
  assign sq_next = $unsigned(ii) + $unsigned(qq);

  // Pipeline register for the squared magnitude, samples and qualifier.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq       <= '0;
      sample_i <= '0;
      sample_q <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      sq       <= '0;
      sample_i <= '0;
      sample_q <= '0;
      valid    <= 1'b0;
    end else begin
      sq       <= sq_next;
      sample_i <= noise_i;
      sample_q <= noise_q;
      valid    <= in_valid;
    end
  end

endmodule

// File: rtl/noise_power_est.sv
// Noise power estimator: mean complex power and per-rail DC mean over windows
// of 2^LOG2_N valid samples, with a one-cycle result strobe.
// Optional NOISE_POWER_EST_PEAK_EN adds o_peak = max(|I|,|Q|) over the window.
module noise_power_est
  import noise_est_pkg::*;
#(
  parameter int LOG2_N = 10
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic signed [NBT_IN-1:0]  i_noise_I,
  input  logic signed [NBT_IN-1:0]  i_noise_Q,
  output logic        [NBT_POW-1:0] o_power,
  output logic signed [NBT_IN-1:0]  o_mean_I,
  output logic signed [NBT_IN-1:0]  o_mean_Q,
  output logic                      o_valid,
  output logic                      o_busy
`ifdef NOISE_POWER_EST_PEAK_EN
  ,
  output logic        [NBT_IN-1:0]  o_peak
`endif
);

  localparam int PW = acc_w(LOG2_N);
  localparam int MW = mean_w(LOG2_N);

  state_t state_q, state_d;
  logic   accept;
  logic   abort;

  logic        [NBT_POW-1:0] s1_sq;
  logic signed [NBT_IN-1:0]  s1_i;
  logic signed [NBT_IN-1:0]  s1_q;
  logic                      s1_valid;

  logic        [PW-1:0]     acc_p;
  logic signed [MW-1:0]     acc_i;
  logic signed [MW-1:0]     acc_q;
  logic        [LOG2_N-1:0] cnt;

  logic        [PW-1:0]     p_sum;
  logic signed [MW-1:0]     i_sum;
  logic signed [MW-1:0]     q_sum;
  logic                     window_end;

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, sample acceptance (including the entry cycle) and abort.
  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = ACCUM;
          accept  = i_valid;
        end
      end
      ACCUM: begin
        if (!i_enable) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else begin
          accept  = i_valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q == ACCUM);

  npe_square_stage u_square (
    .clk      (i_clock),
    .rst      (i_reset),
    .flush    (abort),
    .in_valid (accept),
    .noise_i  (i_noise_I),
    .noise_q  (i_noise_Q),
    .sq       (s1_sq),
    .sample_i (s1_i),
    .sample_q (s1_q),
    .valid    (s1_valid)
  );

  // Running totals including the term currently leaving stage 1; at window
  // end these are the full-window sums that get scaled into the outputs.
  assign p_sum      = acc_p + {{LOG2_N{1'b0}}, s1_sq};
  assign i_sum      = acc_i + {{LOG2_N{s1_i[NBT_IN-1]}}, s1_i};
  assign q_sum      = acc_q + {{LOG2_N{s1_q[NBT_IN-1]}}, s1_q};
  assign window_end = s1_valid && (cnt == '1);

  // Accumulators and sample counter; reload to zero at window end so the
  // next sample opens a new window with no gap.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc_p <= '0;
      acc_i <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else if (abort) begin
      acc_p <= '0;
      acc_i <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else if (s1_valid) begin
      cnt <= cnt + 1'b1;
      if (window_end) begin
        acc_p <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        acc_p <= p_sum;
        acc_i <= i_sum;
        acc_q <= q_sum;
      end
    end
  end

  // Result registers: dropping the low LOG2_N bits divides by the window
  // length, flooring toward -inf for the signed means. Held between strobes.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_power  <= '0;
      o_mean_I <= '0;
      o_mean_Q <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!abort && window_end) begin
        o_valid  <= 1'b1;
        o_power  <= p_sum[PW-1:LOG2_N];
        o_mean_I <= i_sum[MW-1:LOG2_N];
        o_mean_Q <= q_sum[MW-1:LOG2_N];
      end
    end
  end

`ifdef NOISE_POWER_EST_PEAK_EN
  logic [NBT_IN-1:0] abs_i;
  logic [NBT_IN-1:0] abs_q;
  logic [NBT_IN-1:0] peak_q;
  logic [NBT_IN-1:0] peak_next;

  // Magnitudes as unsigned U(8,7); |-128| = 128 fits in 8 unsigned bits.
  always_comb begin
    abs_i     = s1_i[NBT_IN-1] ? $unsigned(-s1_i) : $unsigned(s1_i);
    abs_q     = s1_q[NBT_IN-1] ? $unsigned(-s1_q) : $unsigned(s1_q);
    peak_next = peak_q;
    if (abs_i > peak_next) peak_next = abs_i;
    if (abs_q > peak_next) peak_next = abs_q;
  end

  // Window peak tracker, published alongside the other results.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      peak_q <= '0;
      o_peak <= '0;
    end else if (abort) begin
      peak_q <= '0;
    end else if (s1_valid) begin
      if (window_end) begin
        peak_q <= '0;
        o_peak <= peak_next;
      end else begin
        peak_q <= peak_next;
      end
    end
  end
`endif

endmodule
